// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus controller.
// - state_e        : controller FSM states
// - ErrDataDefault : read data returned with an error response
// - Def*           : default decode geometry used by the controller and by peripherals
// - sel_width()    : width of the peripheral select field for a given channel count
package bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRsp,
    StErrRsp
  } state_e;

  localparam logic [31:0] ErrDataDefault = 32'hDEAD_BEEF;

  localparam int unsigned DefAddrW     = 14;
  localparam int unsigned DefNumPeriph = 6;
  localparam int unsigned DefSelLsb    = 6;
  localparam int unsigned DefRegW      = 6;

  // A single channel still needs a one-bit field so the slice stays legal.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/periph_bus_ctrl_if.sv
// Core data-port bundle (req/gnt/rvalid protocol).
// - master modport : the core side (drives req/we/be/addr/wdata)
// - slave modport  : the controller side (drives gnt/rvalid/rdata/err)
interface periph_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 14
) ();

  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/bus_decode.sv
// Address decode for the peripheral bus controller (purely combinational).
// - addr     : master byte address
// - is_mem   : address lies in the data-memory half
// - idx      : peripheral channel index taken from the select field
// - unmapped : peripheral space but no channel behind idx
module bus_decode
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned NUM_PERIPH = DefNumPeriph,
  parameter int unsigned SEL_LSB    = DefSelLsb,
  localparam int unsigned SEL_W     = sel_width(NUM_PERIPH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              is_mem,
  output logic [SEL_W-1:0]  idx,
  output logic              unmapped
);

  // Only the space bit and the select field matter here.
  logic unused_addr;
  assign unused_addr = ^addr;

  always_comb begin
    is_mem   = ~addr[ADDR_W-1];
    idx      = addr[SEL_LSB +: SEL_W];
    unmapped = ~is_mem && (32'(idx) >= NUM_PERIPH);
  end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Single-master bus controller: routes core data-port transactions to one data memory
// or one of NUM_PERIPH peripheral channels, one transaction outstanding at a time.
// Unmapped addresses and slaves exceeding TIMEOUT wait cycles get an error response.
// Ports:
// - clk_i, rst_i        : clock, asynchronous active-low reset
// - data                : core data port (slave modport)
// - mem_*               : data-memory handshake
// - per_*               : per-channel handshake, per_rdata_i flattened 32 bits/channel
// - slv_*               : request fields shared by all slaves
module periph_bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned NUM_PERIPH = DefNumPeriph,
  parameter int unsigned SEL_LSB    = DefSelLsb,
  parameter int unsigned REG_W      = DefRegW,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = ErrDataDefault
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  periph_bus_ctrl_if.slave         data,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [31:0]              mem_rdata_i,
  output logic [NUM_PERIPH-1:0]    per_req_o,
  input  logic [NUM_PERIPH-1:0]    per_gnt_i,
  input  logic [NUM_PERIPH-1:0]    per_rvalid_i,
  input  logic [32*NUM_PERIPH-1:0] per_rdata_i,
  output logic                     slv_we_o,
  output logic [3:0]               slv_be_o,
  output logic [ADDR_W-2:0]        slv_addr_o,
  output logic [31:0]              slv_wdata_o
);

  localparam int unsigned SEL_W = sel_width(NUM_PERIPH);
  // Only needs to reach TIMEOUT-1; the firing cycle itself moves the FSM on.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tgt_mem_q;
  logic [SEL_W-1:0]   tgt_idx_q;
  logic               rvalid_q, err_q;
  logic [31:0]        rdata_q;

  logic               dec_is_mem, dec_unmapped;
  logic [SEL_W-1:0]   dec_idx;
  logic               sel_gnt, tgt_rvalid, wait_cycle, fire;
  logic [31:0]        tgt_rdata;
  logic               cap, cap_err, latch_tgt;
  logic [31:0]        cap_data;

  bus_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_PERIPH(NUM_PERIPH),
    .SEL_LSB   (SEL_LSB)
  ) u_decode (
    .addr    (data.addr),
    .is_mem  (dec_is_mem),
    .idx     (dec_idx),
    .unmapped(dec_unmapped)
  );

  assign slv_we_o    = data.we;
  assign slv_be_o    = data.be;
  assign slv_addr_o  = data.addr[ADDR_W-2:0];
  assign slv_wdata_o = data.wdata;

  assign data.rvalid = rvalid_q;
  assign data.rdata  = rdata_q;
  assign data.err    = err_q;

  always_comb begin
    sel_gnt    = dec_is_mem ? mem_gnt_i : per_gnt_i[dec_idx];
    tgt_rvalid = tgt_mem_q ? mem_rvalid_i : per_rvalid_i[tgt_idx_q];
    tgt_rdata  = tgt_mem_q ? mem_rdata_i : per_rdata_i[32*int'(tgt_idx_q) +: 32];
    wait_cycle = (state_q == StWaitRsp) ||
                 ((state_q == StIdle) && data.req && !dec_unmapped && !sel_gnt);
    // cnt_q counts earlier wait cycles, so this is the TIMEOUT-th one.
    fire       = (TIMEOUT != 0) && wait_cycle && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cap       = 1'b0;
    cap_err   = 1'b0;
    cap_data  = tgt_rdata;
    latch_tgt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data.req) begin
          if (dec_unmapped || fire) begin
            state_d  = StErrRsp;
            cap      = 1'b1;
            cap_err  = 1'b1;
            cap_data = ERR_DATA;
          end else if (sel_gnt) begin
            state_d   = StWaitRsp;
            latch_tgt = 1'b1;
          end
        end
      end
      StWaitRsp: begin
        // A real response wins over a timeout firing in the same cycle.
        if (tgt_rvalid) begin
          state_d = StIdle;
          cap     = 1'b1;
        end else if (fire) begin
          state_d  = StIdle;
          cap      = 1'b1;
          cap_err  = 1'b1;
          cap_data = ERR_DATA;
        end
      end
      StErrRsp: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if ((state_d != state_q) || data.gnt) begin
      cnt_d = '0;
    end else if (wait_cycle && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    data.gnt  = 1'b0;
    mem_req_o = 1'b0;
    per_req_o = '0;
    if ((state_q == StIdle) && data.req) begin
      if (dec_unmapped || fire) begin
        data.gnt = 1'b1;
      end else begin
        data.gnt = sel_gnt;
        if (dec_is_mem) begin
          mem_req_o = 1'b1;
        end else begin
          per_req_o[dec_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      tgt_mem_q <= 1'b0;
      tgt_idx_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= cap;
      if (latch_tgt) begin
        tgt_mem_q <= dec_is_mem;
        tgt_idx_q <= dec_idx;
      end
      if (cap) begin
        rdata_q <= cap_data;
        err_q   <= cap_err;
      end
    end
  end

endmodule
